// File: rtl/mpmem_pkg.sv
// Shared definitions for the multi-port memory: latency legality, depth helper
// and the read-pipeline tag carried alongside the data in each port stage.
package mpmem_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic bit rd_lat_ok(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    // Control half of a read stage; the data half is sized by each port.
    typedef struct packed {
        logic valid;
        logic hit;
    } rd_tag_t;

endpackage

// File: rtl/mpmem_rdport.sv
// One read port: issue capture, optional write-first bypass (MPMEM_BYPASS_EN)
// and RD_LAT register stages. Data and hit hold when no read is issued.
module mpmem_rdport
    import mpmem_pkg::*;
#(
    parameter int DW     = 4,
    parameter int AW     = 4,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          re,
    input  logic [AW-1:0] ra,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_hit,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    output logic [DW-1:0] rd,
    output logic          rhit,
    output logic          rvalid
);

    typedef struct packed {
        rd_tag_t       tag;
        logic [DW-1:0] data;
    } rd_stage_t;

    rd_stage_t stg_q [RD_LAT];
    rd_stage_t stg_d;

    always_comb begin
        stg_d           = stg_q[0];
        stg_d.tag.valid = re;
        if (re) begin
            stg_d.tag.hit = mem_hit;
            stg_d.data    = mem_rdata;
`ifdef MPMEM_BYPASS_EN
            if (we && (wa == ra)) begin
                stg_d.tag.hit = 1'b1;
                stg_d.data    = wd;
            end
`endif
        end
    end

`ifndef MPMEM_BYPASS_EN
    logic unused_wr;
    assign unused_wr = ^{we, wa, wd};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < RD_LAT; k++) stg_q[k] <= '0;
        end else begin
            stg_q[0] <= stg_d;
            for (int k = 1; k < RD_LAT; k++) stg_q[k] <= stg_q[k-1];
        end
    end

    assign rd     = stg_q[RD_LAT-1].data;
    assign rhit   = stg_q[RD_LAT-1].tag.hit;
    assign rvalid = stg_q[RD_LAT-1].tag.valid;

endmodule

// File: rtl/mpmem.sv
// Single-clock memory, one write port, NR read ports, written-bitmap and fill
// count with synchronous clear. Define MPMEM_BYPASS_EN for write-first reads.
module mpmem
    import mpmem_pkg::*;
#(
    parameter int DW     = 4,
    parameter int AW     = 4,
    parameter int NR     = 2,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [DW-1:0]    wd,
    input  logic [NR-1:0]    re,
    input  logic [NR*AW-1:0] ra,
    output logic [NR*DW-1:0] rd,
    output logic [NR-1:0]    rvalid,
    output logic [NR-1:0]    rhit,
    output logic [AW:0]      fill
);

    localparam int DEPTH = depth_of(AW);

    if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
        $error("mpmem: RD_LAT must be 1 or 2");
    end

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DEPTH-1:0] written_q, written_d;
    logic [AW:0]      fill_q, fill_d;

    // Storage is deliberately not reset; only the bitmap says what is valid.
    always_ff @(posedge clk) begin
        if (we && !rst) mem_q[wa] <= wd;
    end

    // Clear happens before the same-edge write marks its address.
    always_comb begin
        written_d = clr ? '0 : written_q;
        fill_d    = clr ? '0 : fill_q;
        if (we) begin
            if (!written_d[wa]) fill_d = fill_d + (AW+1)'(1);
            written_d[wa] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            written_q <= '0;
            fill_q    <= '0;
        end else begin
            written_q <= written_d;
            fill_q    <= fill_d;
        end
    end

    assign fill = fill_q;

    for (genvar i = 0; i < NR; i++) begin : g_rd
        mpmem_rdport #(
            .DW     (DW),
            .AW     (AW),
            .RD_LAT (RD_LAT)
        ) u_rdport (
            .clk       (clk),
            .rst       (rst),
            .re        (re[i]),
            .ra        (ra[i*AW +: AW]),
            .mem_rdata (mem_q[ra[i*AW +: AW]]),
            .mem_hit   (written_q[ra[i*AW +: AW]]),
            .we        (we),
            .wa        (wa),
            .wd        (wd),
            .rd        (rd[i*DW +: DW]),
            .rhit      (rhit[i]),
            .rvalid    (rvalid[i])
        );
    end

endmodule

// File: tb/tb_mpmem.sv
// Directed bench for mpmem: one RD_LAT=1 and one RD_LAT=2 instance share inputs.
module tb_mpmem;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       we  = 1'b0;
    logic [3:0] wa  = '0;
    logic [3:0] wd  = '0;
    logic [1:0] re  = '0;
    logic [7:0] ra  = '0;

    logic [7:0] rd1, rd2;
    logic [1:0] rv1, rv2, rh1, rh2;
    logic [4:0] fill1, fill2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mpmem #(.DW(4), .AW(4), .NR(2), .RD_LAT(1)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .wa(wa), .wd(wd),
        .re(re), .ra(ra), .rd(rd1), .rvalid(rv1), .rhit(rh1), .fill(fill1)
    );

    mpmem #(.DW(4), .AW(4), .NR(2), .RD_LAT(2)) u2 (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .wa(wa), .wd(wd),
        .re(re), .ra(ra), .rd(rd2), .rvalid(rv2), .rhit(rh2), .fill(fill2)
    );

`ifdef MPMEM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] d);
        we = 1'b1; wa = a; wd = d;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) tick();
        n_chk++;
        if ({rd1, rv1, rh1, fill1} !== 17'h0) $display("FAIL reset_lat1 got=%h exp=0", {rd1, rv1, rh1, fill1});
        else n_pass++;
        n_chk++;
        if ({rd2, rv2, rh2, fill2} !== 17'h0) $display("FAIL reset_lat2 got=%h exp=0", {rd2, rv2, rh2, fill2});
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read_unwritten;
        re = 2'b01; ra = 8'h03;
        tick();
        re = 2'b00;
        n_chk++;
        if ({rv1, rh1, fill1} !== {2'b01, 2'b00, 5'd0}) $display("FAIL unwritten_read got=%b exp=%b", {rv1, rh1, fill1}, {2'b01, 2'b00, 5'd0});
        else n_pass++;
        tick();
    endtask

    task automatic test_rewrite;
        do_write(4'd5, 4'hA);
        do_write(4'd5, 4'hB);
        n_chk++;
        if (fill1 !== 5'd1) $display("FAIL rewrite_fill got=%0d exp=1", fill1);
        else n_pass++;
        re = 2'b11; ra = 8'h55;
        tick();
        re = 2'b00;
        n_chk++;
        if ({rd1, rh1, rv1} !== {8'hBB, 2'b11, 2'b11}) $display("FAIL rewrite_read got=%h exp=%h", {rd1, rh1, rv1}, {8'hBB, 2'b11, 2'b11});
        else n_pass++;
        tick();
        n_chk++;
        if ({rd1, rh1, rv1} !== {8'hBB, 2'b11, 2'b00}) $display("FAIL idle_hold got=%h exp=%h", {rd1, rh1, rv1}, {8'hBB, 2'b11, 2'b00});
        else n_pass++;
        n_chk++;
        if ({rd2, rh2, rv2} !== {8'hBB, 2'b11, 2'b11}) $display("FAIL rewrite_lat2 got=%h exp=%h", {rd2, rh2, rv2}, {8'hBB, 2'b11, 2'b11});
        else n_pass++;
    endtask

    task automatic test_clr_and_bypass;
        logic [3:0] exp_d;
        do_write(4'd7, 4'h3);
        n_chk++;
        if (fill1 !== 5'd2) $display("FAIL fill_two got=%0d exp=2", fill1);
        else n_pass++;
        // read in the clr cycle must still see the old bitmap
        clr = 1'b1; re = 2'b01; ra = 8'h05;
        tick();
        clr = 1'b0; re = 2'b00;
        n_chk++;
        if ({fill1, rd1[3:0], rh1[0]} !== {5'd0, 4'hB, 1'b1}) $display("FAIL clr_preclear got=%h exp=%h", {fill1, rd1[3:0], rh1[0]}, {5'd0, 4'hB, 1'b1});
        else n_pass++;
        we = 1'b1; wa = 4'd7; wd = 4'hC; re = 2'b10; ra = 8'h70;
        tick();
        we = 1'b0; re = 2'b00;
        exp_d = BYP ? 4'hC : 4'h3;
        n_chk++;
        if ({rd1[7:4], rh1[1], fill1} !== {exp_d, BYP, 5'd1}) $display("FAIL rdw_same_addr got=%h exp=%h", {rd1[7:4], rh1[1], fill1}, {exp_d, BYP, 5'd1});
        else n_pass++;
        re = 2'b10; ra = 8'h70;
        tick();
        re = 2'b00;
        n_chk++;
        if ({rd1[7:4], rh1[1]} !== {4'hC, 1'b1}) $display("FAIL after_write got=%h exp=%h", {rd1[7:4], rh1[1]}, {4'hC, 1'b1});
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] e_rd1, e_rd2;
        logic [1:0] e_rv1, e_rv2;
        do_write(4'd1, 4'h1);
        do_write(4'd2, 4'h2);
        do_write(4'd3, 4'h3);
        e_rd2 = rd2;
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin
                re = 2'b11; ra = {2{4'(k + 1)}};
            end else begin
                re = 2'b00;
            end
            tick();
            e_rv1 = (k < 3) ? 2'b11 : 2'b00;
            e_rd1 = (k < 3) ? {2{4'(k + 1)}} : 8'h33;
            e_rv2 = (k >= 1 && k <= 3) ? 2'b11 : 2'b00;
            if (k >= 1 && k <= 3) e_rd2 = {2{4'(k)}};
            n_chk++;
            if ({rd1, rv1} !== {e_rd1, e_rv1}) $display("FAIL b2b_lat1 k=%0d got=%h exp=%h", k, {rd1, rv1}, {e_rd1, e_rv1});
            else n_pass++;
            n_chk++;
            if ({rd2, rv2} !== {e_rd2, e_rv2}) $display("FAIL b2b_lat2 k=%0d got=%h exp=%h", k, {rd2, rv2}, {e_rd2, e_rv2});
            else n_pass++;
        end
    endtask

    task automatic test_fill_full;
        logic [3:0] exp_d;
        for (int a = 0; a < 16; a++) do_write(4'(a), 4'(a) ^ 4'hF);
        n_chk++;
        if (fill1 !== 5'd16) $display("FAIL fill_full got=%0d exp=16", fill1);
        else n_pass++;
        clr = 1'b1; we = 1'b1; wa = 4'd0; wd = 4'h9;
        tick();
        clr = 1'b0; we = 1'b0;
        n_chk++;
        if ({fill1, fill2} !== {5'd1, 5'd1}) $display("FAIL clr_with_we got=%h exp=%h", {fill1, fill2}, {5'd1, 5'd1});
        else n_pass++;
        for (int a = 0; a < 16; a++) begin
            re = 2'b01; ra = {4'h0, 4'(a)};
            tick();
            exp_d = (a == 0) ? 4'h9 : (4'(a) ^ 4'hF);
            n_chk++;
            if ({rd1[3:0], rh1[0]} !== {exp_d, a == 0}) $display("FAIL scan addr=%0d got=%h exp=%h", a, {rd1[3:0], rh1[0]}, {exp_d, a == 0});
            else n_pass++;
        end
        re = 2'b00;
        tick();
    endtask

    task automatic test_reset_midstream;
        re = 2'b11; ra = 8'h11;
        tick();
        ra = 8'h22;
        tick();
        rst = 1'b1;
        #1;
        n_chk++;
        if ({rd1, rv1, rh1, rd2, rv2, rh2, fill1} !== 29'h0) $display("FAIL rst_async got=%h exp=0", {rd1, rv1, rh1, rd2, rv2, rh2, fill1});
        else n_pass++;
        we = 1'b1; wa = 4'd4; wd = 4'h5;
        tick();
        rst = 1'b0; we = 1'b0; re = 2'b00;
        tick();
        n_chk++;
        if ({rv1, rv2, fill1} !== 9'h0) $display("FAIL rst_release got=%h exp=0", {rv1, rv2, fill1});
        else n_pass++;
        re = 2'b01; ra = 8'h00;
        tick();
        re = 2'b00;
        n_chk++;
        if ({rd1, rv1, rh1, rv2} !== {8'h09, 2'b01, 2'b00, 2'b00}) $display("FAIL post_rst_lat1 got=%h exp=%h", {rd1, rv1, rh1, rv2}, {8'h09, 2'b01, 2'b00, 2'b00});
        else n_pass++;
        tick();
        n_chk++;
        if ({rd2, rv2, rh2} !== {8'h09, 2'b01, 2'b00}) $display("FAIL post_rst_lat2 got=%h exp=%h", {rd2, rv2, rh2}, {8'h09, 2'b01, 2'b00});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_read_unwritten();
        test_rewrite();
        test_clr_and_bypass();
        test_back_to_back();
        test_fill_full();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mpmem.md
Name: mpmem

Overview:
- Single-clock, parametrised memory with one write port and NR independent read ports.
- Successor to the two-clock 4x16 dual-port memory: adds generic width/depth, multiple read ports, selectable read latency, per-entry "written" tracking with a fill counter, and a synchronous clear.
- Sits behind register files and lookup tables in the formal-example designs; its written-flag output lets shadow-model checkers skip never-written addresses.

Parameters:
- DW, 4, data width in bits (≥1)
- AW, 4, address width; depth = 2**AW
- NR, 2, number of read ports (1..8)
- RD_LAT, 1, read latency in cycles; legal values 1 or 2 only, anything else is an elaboration error

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous clear of all written flags and fill
- we  in  1  write enable
- wa  in  AW  write address
- wd  in  DW  write data
- re  in  NR  per-port read enable
- ra  in  NR*AW  read addresses, port i at [i*AW +: AW]
- rd  out  NR*DW  read data, port i at [i*DW +: DW]
- rvalid  out  NR  per-port read-data valid
- rhit  out  NR  per-port: addressed entry had been written, as seen at the issue cycle
- fill  out  AW+1  count of distinct addresses written since reset/clr

Behaviour:
- Reset (async assert): rd=0, rvalid=0, rhit=0, fill=0, written bitmap all 0, all pipeline stages cleared. Storage array is not reset.
- While rst is high, we/re/clr are ignored. In-flight reads are dropped; the first cycle after deassert shows rvalid=0.
- Write: on a clk edge with we=1, mem[wa] <= wd and written[wa] <= 1.
  - fill increments only if written[wa] was 0 before the edge.
  - fill saturates naturally at 2**AW, which needs the AW+1 width.
- Read issue on port i, at edge N with re[i]=1:
  - Captures mem[ra_i], written[ra_i] and the valid bit.
  - RD_LAT=1: rd_i, rhit_i and rvalid_i update at edge N.
  - RD_LAT=2: an extra register stage; outputs update at edge N+1.
  - The pipeline is fully pipelined: a new read may issue every cycle on every port.
- re[i]=0: rvalid_i drops to 0 at the corresponding output edge; rd_i and rhit_i hold their previous values.
- Simultaneous ports reading the same address: each port returns identical data and rhit.
- Read-during-write at the same address in the same cycle: governed by MPMEM_BYPASS_EN (see Optional Feature).
- clr=1 at an edge: bitmap cleared and fill=0; contents are kept.
  - clr with we at the same edge: the clear applies first, then the write marks wa, so fill=1 and written[wa]=1.
  - A read issued in the same cycle as clr sees the pre-clear bitmap.
- Address wrap: none; addresses are full-range, so every AW-bit value is legal.

Optional Feature:
- Macro MPMEM_BYPASS_EN.
- Defined (write-first): a read issued at the same edge as a write to the same address returns wd and rhit=1.
- Undefined (read-first): the read returns the old mem contents and the old written flag.
- Both modes: fill and bitmap behaviour unchanged; the bypass compare is per port.

Decomposition:
- Package mpmem_pkg holds:
  - RD_LAT legality constant and check function
  - typedef for the per-port read pipeline stage struct: {valid, hit, data}
  - localparam helper for depth (2**AW)
- One natural sub-module, mpmem_rdport: a single read port including its latency stage(s) and bypass compare, instantiated NR times with a generate loop.
- The top level owns storage, the written bitmap and the fill counter.

Test Plan:
- Reset then read address 3 on port 0, RD_LAT=1 → rvalid=1, rhit=0 one cycle later; fill=0.
- Write 0xA to addr 5, then write 0xB to addr 5 → fill=1 (not 2); read of addr 5 returns 0xB, rhit=1.
- Same edge: we to addr 7 with data 0xC, port 1 reads addr 7 → returns 0xC with MPMEM_BYPASS_EN; returns the previous value with rhit=0 without it.
- RD_LAT=2, back-to-back reads of addr 1,2,3 on both ports → data appears 2 edges after each issue, in order, rvalid stays high 3 cycles.
- Write all 16 addresses (AW=4) → fill=16. Then clr and we to addr 0 at the same edge → fill=1, only addr 0 reads rhit=1.
- Assert rst mid-stream with RD_LAT=2 and reads in flight → outputs zero immediately; after deassert, rvalid=0 until the next read completes.
